// File: rtl/card_dealer.sv
// Deals a hand of four cards in 1..MAX_VAL by rejection-sampling an external
// 4-bit generator, forcing a card to 1 after MAX_REJECT consecutive rejects.
module card_dealer #(
  parameter int MAX_VAL    = 9,
  parameter int MAX_REJECT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       deal_req,
  input  logic [3:0] rng_val,
  output logic       rng_en,
  output logic       busy,
  output logic       done,
  output logic       fallback,
  output logic [3:0] card0,
  output logic [3:0] card1,
  output logic [3:0] card2,
  output logic [3:0] card3
);

  typedef enum logic [1:0] {IDLE, DRAW, CHECK, DONE} state_t;

  localparam logic [3:0] MAX_VAL_L    = 4'(MAX_VAL);
  localparam logic [3:0] MAX_REJECT_L = 4'(MAX_REJECT);

  state_t     state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic [3:0] rej_cnt_reg, rej_cnt_next;
  logic       fallback_reg, fallback_next;
  logic [3:0] card_reg  [4];
  logic [3:0] card_next [4];
  logic       val_ok;

  assign val_ok = (rng_val != 4'd0) && (rng_val <= MAX_VAL_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      idx_reg      <= 2'd0;
      rej_cnt_reg  <= 4'd0;
      fallback_reg <= 1'b0;
      for (int i = 0; i < 4; i++) card_reg[i] <= 4'd0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      rej_cnt_reg  <= rej_cnt_next;
      fallback_reg <= fallback_next;
      for (int i = 0; i < 4; i++) card_reg[i] <= card_next[i];
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    rej_cnt_next  = rej_cnt_reg;
    fallback_next = fallback_reg;
    for (int i = 0; i < 4; i++) card_next[i] = card_reg[i];

    case (state_reg)
      IDLE: begin
        if (deal_req) begin
          idx_next      = 2'd0;
          rej_cnt_next  = 4'd0;
          fallback_next = 1'b0;
          for (int i = 0; i < 4; i++) card_next[i] = 4'd0;
          state_next    = DRAW;
        end
      end
      DRAW: state_next = CHECK;
      CHECK: begin
        // An exhausted reject budget is treated as an accept of the value 1.
        if (val_ok || (rej_cnt_reg >= MAX_REJECT_L)) begin
          card_next[idx_reg] = val_ok ? rng_val : 4'd1;
          if (!val_ok) fallback_next = 1'b1;
          rej_cnt_next = 4'd0;
          if (idx_reg == 2'd3) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = DRAW;
          end
        end else begin
          rej_cnt_next = rej_cnt_reg + 4'd1;
          state_next   = DRAW;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode directly from the state register, so they cannot glitch.
  assign rng_en   = (state_reg == DRAW);
  assign busy     = (state_reg == DRAW) || (state_reg == CHECK);
  assign done     = (state_reg == DONE);
  assign fallback = fallback_reg;
  assign card0    = card_reg[0];
  assign card1    = card_reg[1];
  assign card2    = card_reg[2];
  assign card3    = card_reg[3];

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a generator model feeds rng_val, stimulus
// pushes expected hands, and a monitor checks each hand when done pulses.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic       deal_req;
  logic [3:0] rng_val;
  logic       rng_en, busy, done, fallback;
  logic [3:0] card0, card1, card2, card3;

  always #5 clk = ~clk;

  card_dealer #(.MAX_VAL(9), .MAX_REJECT(15)) dut (
    .clk(clk), .rst(rst), .deal_req(deal_req), .rng_val(rng_val),
    .rng_en(rng_en), .busy(busy), .done(done), .fallback(fallback),
    .card0(card0), .card1(card1), .card2(card2), .card3(card3)
  );

  typedef struct {
    int c0, c1, c2, c3;
    int fb;
    int cyc;
    int pulses;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Generator model: steps once per clock edge on which rng_en was high.
  logic [3:0] gen_seq[$];
  int         gen_ptr = -1;
  bit         stuck = 1'b0;
  bit         gen_adv;

  initial begin
    rng_val = 4'd0;
    forever begin
      @(negedge clk);
      gen_adv = (rng_en === 1'b1);
      @(posedge clk);
      #1;
      if (gen_adv) gen_ptr++;
      if (stuck) rng_val = 4'd15;
      else if (gen_ptr >= 0 && gen_ptr < gen_seq.size()) rng_val = gen_seq[gen_ptr];
      else rng_val = 4'd0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int c0, c1, c2, c3, fb, cyc, pulses);
    exp_t e;
    e.c0 = c0; e.c1 = c1; e.c2 = c2; e.c3 = c3;
    e.fb = fb; e.cyc = cyc; e.pulses = pulses;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no done within %0d cycles, expected done", name, budget);
    end
  endtask

  // Starts a deal from an IDLE negedge with a one-cycle request.
  task automatic run_deal(input int budget, input string name);
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    wait_done(budget, name);
  endtask

  // Monitor: counts cycles from the first DRAW and rng_en pulses per deal.
  int mon_cyc = 0;
  int mon_pulses = 0;
  bit prev_busy = 1'b0;
  bit prev_en = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && !prev_busy) begin
        mon_cyc = 1;
        mon_pulses = 0;
      end else begin
        mon_cyc++;
      end
      if (rng_en === 1'b1) mon_pulses++;
      if (rng_en === 1'b1 && prev_en) begin
        vectors++;
        miscompares++;
        $display("FAIL rng_en_consecutive: got 2 back-to-back cycles, expected at most 1");
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done pulse, expected none");
        end else begin
          e = sb.pop_front();
          chk("card0", int'(card0), e.c0);
          chk("card1", int'(card1), e.c1);
          chk("card2", int'(card2), e.c2);
          chk("card3", int'(card3), e.c3);
          chk("fallback", int'(fallback), e.fb);
          chk("done_cycle", mon_cyc, e.cyc);
          chk("rng_pulses", mon_pulses, e.pulses);
          $display("deal checked: cards %0d %0d %0d %0d fb=%0d cycle=%0d pulses=%0d",
                   card0, card1, card2, card3, fallback, mon_cyc, mon_pulses);
        end
      end
      prev_busy = (busy === 1'b1);
      prev_en   = (rng_en === 1'b1);
    end
  end

  initial begin
    rst = 1'b1;
    deal_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rng_en", int'(rng_en), 0);
    chk("rst_fallback", int'(fallback), 0);
    chk("rst_card0", int'(card0), 0);
    chk("rst_card3", int'(card3), 0);
    rst = 1'b0;

    // clean deal
    @(negedge clk);
    gen_seq = '{4'd3, 4'd7, 4'd1, 4'd9}; gen_ptr = -1;
    push_exp(3, 7, 1, 9, 0, 9, 4);
    run_deal(40, "clean");

    // rejects: 0,12,15 rejected
    @(negedge clk);
    gen_seq = '{4'd0, 4'd12, 4'd5, 4'd15, 4'd2, 4'd8, 4'd6}; gen_ptr = -1;
    push_exp(5, 2, 8, 6, 0, 15, 7);
    run_deal(60, "rejects");

    // boundary values around MAX_VAL=9
    @(negedge clk);
    gen_seq = '{4'd10, 4'd9, 4'd1, 4'd0, 4'd15, 4'd4, 4'd13, 4'd2}; gen_ptr = -1;
    push_exp(9, 1, 4, 2, 0, 17, 8);
    run_deal(60, "boundary");

    // stuck generator forces every card
    @(negedge clk);
    stuck = 1'b1;
    push_exp(1, 1, 1, 1, 1, 129, 64);
    run_deal(200, "stuck");
    repeat (2) @(negedge clk);
    chk("fallback_hold", int'(fallback), 1);
    chk("card2_hold", int'(card2), 1);
    chk("idle_busy", int'(busy), 0);
    stuck = 1'b0;

    // a fresh deal clears fallback
    gen_seq = '{4'd2, 4'd2, 4'd2, 4'd2}; gen_ptr = -1;
    push_exp(2, 2, 2, 2, 0, 9, 4);
    run_deal(40, "clear_fb");

    // reset in the CHECK of card 2
    @(negedge clk);
    gen_seq = '{4'd4, 4'd5, 4'd6, 4'd7}; gen_ptr = -1;
    deal_req = 1'b1;
    @(negedge clk);
    deal_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    chk("mid_rng_en", int'(rng_en), 0);
    chk("mid_card1", int'(card1), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_card0", int'(card0), 0);
    chk("abort_card1", int'(card1), 0);
    gen_seq = '{4'd1, 4'd2, 4'd3, 4'd4}; gen_ptr = -1;
    push_exp(1, 2, 3, 4, 0, 9, 4);
    run_deal(40, "after_reset");

    // request pulsed during DRAW is ignored
    @(negedge clk);
    gen_seq = '{4'd5, 4'd5, 4'd5, 4'd5}; gen_ptr = -1;
    push_exp(5, 5, 5, 5, 0, 9, 4);
    deal_req = 1'b1;
    @(negedge clk);
    chk("busy_draw_en", int'(rng_en), 1);
    @(negedge clk);
    deal_req = 1'b0;
    wait_done(40, "req_busy");
    repeat (3) @(negedge clk);
    chk("no_requeue", int'(busy), 0);

    // deal_req held high: back-to-back deals, one idle cycle between
    gen_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8}; gen_ptr = -1;
    push_exp(1, 2, 3, 4, 0, 9, 4);
    push_exp(5, 6, 7, 8, 0, 9, 4);
    deal_req = 1'b1;
    wait_done(40, "held_first");
    @(negedge clk);
    chk("gap_idle", int'(busy), 0);
    @(negedge clk);
    chk("gap_restart", int'(busy), 1);
    deal_req = 1'b0;
    wait_done(40, "held_second");

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 SHALL have parameter MAX_VAL, default 9, meaning the largest card value accepted (range 1..15).
REQ-002 SHALL have parameter MAX_REJECT, default 15, meaning the consecutive rejects allowed per card before fallback (range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port deal_req  input  1  request to deal a new hand of four cards.
REQ-006 SHALL have port rng_val  input  4  current output of the 4-bit pseudo-random generator.
REQ-007 SHALL have port rng_en  output  1  enable to the generator; the generator advances one step on each clock edge where rng_en is high.
REQ-008 SHALL have port busy  output  1  high while a deal is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when all four cards are valid.
REQ-010 SHALL have port fallback  output  1  high if any card of the current or last hand was forced to 1.
REQ-011 SHALL have ports card0, card1, card2, card3  output  4 each  dealt card values, each in the range 1..MAX_VAL once done has pulsed.

Function
REQ-012 SHALL implement the FSM states IDLE, DRAW, CHECK and DONE, plus a 2-bit card index idx and a 4-bit reject counter rej_cnt.
REQ-013 IDLE: rng_en=0, busy=0; when deal_req=1, SHALL clear idx, rej_cnt, fallback and all cards, then go to DRAW.
REQ-014 DRAW: rng_en=1, busy=1, and the FSM SHALL go unconditionally to CHECK on the next edge.
REQ-015 CHECK: rng_en=0, busy=1; rng_val SHALL be sampled this cycle (the generator value after the DRAW step).
REQ-016 In CHECK, a value v with 1<=v<=MAX_VAL SHALL be accepted: store card[idx]=v and clear rej_cnt; if idx==3 go to DONE, else increment idx and go to DRAW.
REQ-017 In CHECK, a value v==0 or v>MAX_VAL with rej_cnt<MAX_REJECT SHALL be rejected: increment rej_cnt and go to DRAW; idx and the cards stay unchanged.
REQ-018 In CHECK, an invalid value with rej_cnt==MAX_REJECT SHALL force card[idx]=4'd1, set fallback=1, and then proceed exactly as an accept.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-020 With no rejects, done SHALL be high in the 9th cycle after the edge that sampled deal_req (DRAW/CHECK ×4, then DONE); each reject SHALL add 2 cycles.
REQ-021 deal_req SHALL be ignored in DRAW, CHECK and DONE, with no queuing.
REQ-022 deal_req held high SHALL start a new deal from IDLE on the edge after DONE.
REQ-023 card0..card3 and fallback SHALL hold their values in IDLE until the next accepted deal_req clears them.
REQ-024 rng_en SHALL be a registered or state-decoded output, glitch-free, and high only in DRAW.
REQ-025 The block SHALL never drive rng_en in two consecutive cycles, so each CHECK sees exactly one new generator step.

Reset
REQ-026 When rst=1 at an edge, the block SHALL go to IDLE and set card0..card3=0, idx=0, rej_cnt=0, fallback=0, busy=0, done=0 and rng_en=0.
REQ-027 rst SHALL take priority over deal_req and over any in-progress deal (mid-deal abort, with no done pulse).
REQ-028 The first cycle after rst deasserts SHALL be IDLE, and deal_req SHALL be honoured in that cycle.

Verification
REQ-029 Scenario "clean deal": the generator model returns 3,7,1,9 on successive steps; pulse deal_req -> done high in the 9th cycle, cards 3,7,1,9, fallback=0, and rng_en high for exactly 4 cycles.
REQ-030 Scenario "rejects": the generator returns 0,12,5,15,2,8,6 -> cards 5,2,8,6, done at cycle 15, and rng_en pulses=7.
REQ-031 Scenario "stuck generator": the generator returns constant 15 (XNOR lock-up) -> each card takes 16 CHECKs, cards 1,1,1,1, fallback=1, done at cycle 129.
REQ-032 Scenario "boundary": MAX_VAL=9 with values 10,9,1,0,15,4,13,2 -> 9,1,4,2 accepted, and 10/0/15/13 rejected.
REQ-033 Scenario "reset mid-deal": assert rst in the CHECK of card 2 -> the next cycle is IDLE, cards all 0, no done; a following deal_req deals normally.
REQ-034 Scenario "request while busy": deal_req is pulsed during DRAW -> no effect on the sequence and a single done; deal_req held high continuously -> back-to-back deals with idle gaps of 1 cycle.
